// File: rtl/instr_decode_queue.sv
// Fetch-to-decode instruction queue: DEPTH entries, head split into decode fields, NOP when flushed/empty.
// Latency 1 cycle (push at edge N visible after N); stall_in holds head, instr_ready_out drops when full.
// Optional per-entry PC storage enabled by defining INSTR_QUEUE_PC_EN.
module instr_decode_queue #(
  parameter int              XLEN  = 32,
  parameter int              DEPTH = 4,
  parameter logic [XLEN-1:0] NOP   = 32'h00000013
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       flush_in,
  input  logic                       stall_in,
  input  logic                       instr_valid_in,
  input  logic [XLEN-1:0]            instr_in,
`ifdef INSTR_QUEUE_PC_EN
  input  logic [XLEN-1:0]            pc_in,
  output logic [XLEN-1:0]            pc_out,
`endif
  output logic                       instr_ready_out,
  output logic                       dec_valid_out,
  output logic [6:0]                 opcode_out,
  output logic [2:0]                 funct3_out,
  output logic [6:0]                 funct7_out,
  output logic [4:0]                 rs1_addr_out,
  output logic [4:0]                 rs2_addr_out,
  output logic [4:0]                 rd_addr_out,
  output logic [24:0]                instr_31_7_out,
  output logic [$clog2(DEPTH):0]     count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] head;

  // Plain registered FIFO: a full queue refuses a push even when it pops that cycle.
  assign instr_ready_out = rst_n_in & (count < FULL);
  assign dec_valid_out   = rst_n_in & ~flush_in & (count != '0);
  assign push            = instr_valid_in & instr_ready_out & ~flush_in;
  assign pop             = dec_valid_out & ~stall_in;
  assign count_out       = count;

  assign head            = dec_valid_out ? mem[rd_ptr] : NOP;
  assign opcode_out      = head[6:0];
  assign funct3_out      = head[14:12];
  assign funct7_out      = head[31:25];
  assign rs1_addr_out    = head[19:15];
  assign rs2_addr_out    = head[24:20];
  assign rd_addr_out     = head[11:7];
  assign instr_31_7_out  = head[31:7];

  always_ff @(posedge clk_in) begin
    if (!rst_n_in || flush_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; push already excludes reset and flush.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= instr_in;
  end

`ifdef INSTR_QUEUE_PC_EN
  logic [XLEN-1:0] pc_mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (push) pc_mem[wr_ptr] <= pc_in;
  end

  assign pc_out = dec_valid_out ? pc_mem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_instr_decode_queue.sv
// Bench for instr_decode_queue: directed steps plus random traffic against a queue-based reference model.
module tb_instr_decode_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        flush_in = 1'b0;
  logic        stall_in = 1'b0;
  logic        instr_valid_in = 1'b0;
  logic [31:0] instr_in = '0;
  logic        instr_ready_out;
  logic        dec_valid_out;
  logic [6:0]  opcode_out;
  logic [2:0]  funct3_out;
  logic [6:0]  funct7_out;
  logic [4:0]  rs1_addr_out;
  logic [4:0]  rs2_addr_out;
  logic [4:0]  rd_addr_out;
  logic [24:0] instr_31_7_out;
  logic [2:0]  count_out;
`ifdef INSTR_QUEUE_PC_EN
  logic [31:0] pc_in = '0;
  logic [31:0] pc_out;
`endif

  always #5 clk_in = ~clk_in;

  instr_decode_queue #(.XLEN(32), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .flush_in(flush_in), .stall_in(stall_in),
    .instr_valid_in(instr_valid_in), .instr_in(instr_in),
`ifdef INSTR_QUEUE_PC_EN
    .pc_in(pc_in), .pc_out(pc_out),
`endif
    .instr_ready_out(instr_ready_out), .dec_valid_out(dec_valid_out),
    .opcode_out(opcode_out), .funct3_out(funct3_out), .funct7_out(funct7_out),
    .rs1_addr_out(rs1_addr_out), .rs2_addr_out(rs2_addr_out), .rd_addr_out(rd_addr_out),
    .instr_31_7_out(instr_31_7_out), .count_out(count_out)
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mq[$];
  logic [31:0] mpc[$];
  logic [31:0] next_pc = 32'h00000100;
  bit          model_known = 0;
  logic [31:0] w[5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive mid-cycle, compare against the model, then advance the model.
  task automatic cyc(input logic rst, input logic fl, input logic st, input logic v, input logic [31:0] wd);
    logic        exp_ready, exp_valid, do_push, do_pop;
    logic [31:0] h, hp;
    @(negedge clk_in);
    rst_n_in = rst; flush_in = fl; stall_in = st; instr_valid_in = v; instr_in = wd;
`ifdef INSTR_QUEUE_PC_EN
    pc_in = next_pc;
`endif
    #1;
    exp_ready = rst && (mq.size() < DEPTH);
    exp_valid = rst && !fl && (mq.size() != 0);
    h  = exp_valid ? mq[0]  : NOP;
    hp = exp_valid ? mpc[0] : 32'h0;
    if (model_known) begin
      chk("ready",  32'(instr_ready_out), 32'(exp_ready));
      chk("valid",  32'(dec_valid_out),   32'(exp_valid));
      chk("count",  32'(count_out),       32'(mq.size()));
      chk("opcode", 32'(opcode_out),      32'(h[6:0]));
      chk("funct3", 32'(funct3_out),      32'(h[14:12]));
      chk("funct7", 32'(funct7_out),      32'(h[31:25]));
      chk("rs1",    32'(rs1_addr_out),    32'(h[19:15]));
      chk("rs2",    32'(rs2_addr_out),    32'(h[24:20]));
      chk("rd",     32'(rd_addr_out),     32'(h[11:7]));
      chk("i31_7",  32'(instr_31_7_out),  32'(h[31:7]));
`ifdef INSTR_QUEUE_PC_EN
      chk("pc",     pc_out,               hp);
`endif
    end
    if (!rst || fl) begin
      mq.delete();
      mpc.delete();
      if (!rst) model_known = 1;
    end else begin
      do_pop  = exp_valid && !st;
      do_push = v && exp_ready;
      if (do_pop) begin
        void'(mq.pop_front());
        void'(mpc.pop_front());
      end
      if (do_push) begin
        mq.push_back(wd);
        mpc.push_back(next_pc);
      end
    end
    next_pc = next_pc + 32'd4;
  endtask

  initial begin
    for (int i = 0; i < 5; i++) w[i] = $urandom;

    // Reset, single push, one-cycle latency, then drain.
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 32'h00500093);
    cyc(1, 0, 0, 0, 0);
    chk("t1_valid",  32'(dec_valid_out),  32'd1);
    chk("t1_opcode", 32'(opcode_out),     32'h13);
    chk("t1_rd",     32'(rd_addr_out),    32'd1);
    chk("t1_rs1",    32'(rs1_addr_out),   32'd0);
    chk("t1_funct3", 32'(funct3_out),     32'd0);
    chk("t1_i31_7",  32'(instr_31_7_out), 32'h00A001);
    cyc(1, 0, 0, 0, 0);
    chk("t1_count",  32'(count_out),      32'd0);

    // Fill under stall, refused fifth push, ordered drain.
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 1, w[i]);
    cyc(1, 0, 1, 1, w[4]);
    chk("t2_count", 32'(count_out),       32'd4);
    chk("t2_ready", 32'(instr_ready_out), 32'd0);
    chk("t2_head",  32'(instr_31_7_out),  32'(w[0][31:7]));
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0, 0);
      chk("t2_drain", {instr_31_7_out, opcode_out}, w[i]);
    end
    cyc(1, 0, 0, 0, 0);
    chk("t2_empty", 32'(count_out), 32'd0);

    // Flush with three entries and a concurrent push.
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 1, w[i]);
    cyc(1, 1, 0, 1, w[3]);
    chk("t3_valid",  32'(dec_valid_out), 32'd0);
    chk("t3_opcode", 32'(opcode_out),    32'h13);
    chk("t3_rd",     32'(rd_addr_out),   32'd0);
    cyc(1, 0, 0, 0, 0);
    chk("t3_count",  32'(count_out),     32'd0);

    // Continuous push+pop, pointers wrap.
    cyc(1, 0, 1, 1, $urandom);
    cyc(1, 0, 1, 1, $urandom);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 1, $urandom);
    chk("t4_count", 32'(count_out), 32'd2);

    // Reset mid-operation during stall.
    cyc(1, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, $urandom);
    chk("t5_ready",  32'(instr_ready_out), 32'd0);
    chk("t5_valid",  32'(dec_valid_out),   32'd0);
    chk("t5_opcode", 32'(opcode_out),      32'h13);
    cyc(1, 0, 0, 0, 0);
    chk("t5_count",  32'(count_out),       32'd0);
    chk("t5_ready1", 32'(instr_ready_out), 32'd1);

`ifdef INSTR_QUEUE_PC_EN
    next_pc = 32'h00000100;
    cyc(1, 0, 1, 1, w[0]);
    cyc(1, 0, 1, 1, w[1]);
    cyc(1, 0, 0, 0, 0);
    chk("t6_pc0", pc_out, 32'h00000100);
    cyc(1, 0, 0, 0, 0);
    chk("t6_pc1", pc_out, 32'h00000104);
    cyc(1, 0, 0, 0, 0);
    chk("t6_pc_empty", pc_out, 32'h0);
    cyc(1, 0, 1, 1, w[2]);
    cyc(1, 1, 0, 0, 0);
    chk("t6_pc_flush", pc_out, 32'h0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 50) != 0, ($urandom % 12) == 0, ($urandom % 3) == 0,
          ($urandom % 4) != 0, $urandom);
    cyc(1, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
